// File: rtl/l2_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l2_if_pkg
//  Purpose  : Shared widths and transaction state encoding for the L2
//             request arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package l2_if_pkg;

  // Line address is {index[5:0], tag[4:0]}
  localparam int ADDR_W = 11;
  // One full cache line per transfer
  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_RDY    = 3'd1,
    FLUSH_ISSUE = 3'd2,
    FLUSH_START = 3'd3,
    FLUSH_WAIT  = 3'd4
  } l2_state_e;

endpackage : l2_if_pkg
`default_nettype wire

// File: rtl/l2_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Returns the index of the first
//             asserted request at or after the pointer, wrapping at N-1.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_valid
);

  int w_idx;

  // Scan from farthest to nearest offset so the nearest requester wins last
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (i_req[w_idx]) begin
        o_grant = IDX_W'(w_idx);
        o_valid = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : l2_arbiter
//  Purpose  : Round-robin arbiter between L1 line requesters and the L2 cache.
//             Issues one transaction at a time and sequences system flushes,
//             stalling every client while a flush is pending or running.
//  Revision : 1.0  initial release
// ============================================================================
module l2_arbiter
  import l2_if_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = l2_if_pkg::ADDR_W,
  parameter int LINE_W      = l2_if_pkg::LINE_W
) (
  input  logic                          clk,
  input  logic                          rstn,
  // L1 client side
  input  logic [NUM_CLIENTS-1:0]        c_req,
  input  logic [NUM_CLIENTS-1:0]        c_w_rb,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] c_addr,
  input  logic [NUM_CLIENTS*LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0]             c_rdata,
  output logic [NUM_CLIENTS-1:0]        c_ready,
  // System flush control
  input  logic                          sys_flush_req,
  output logic                          flush_busy,
  // L2 side
  output logic                          arb_req,
  output logic                          arb_w_rb,
  output logic [ADDR_W-1:0]             addr_in,
  output logic [LINE_W-1:0]             wdata2cache,
  output logic                          flush_req,
  input  logic [LINE_W-1:0]             rdata2arb,
  input  logic                          ready2arb,
  input  logic                          flush_ing
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  l2_state_e               r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]        r_grant, w_grant_nxt;
  logic                    r_flush_pend, w_flush_pend_nxt;
  logic                    r_arb_req, w_arb_req_nxt;
  logic                    r_arb_w_rb, w_arb_w_rb_nxt;
  logic [ADDR_W-1:0]       r_addr, w_addr_nxt;
  logic [LINE_W-1:0]       r_wdata, w_wdata_nxt;
  logic                    r_flush_req, w_flush_req_nxt;
  logic [NUM_CLIENTS-1:0]  r_c_ready, w_c_ready_nxt;
  logic [LINE_W-1:0]       r_c_rdata, w_c_rdata_nxt;

  logic [NUM_CLIENTS-1:0]  w_req_mask;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_vld;
  logic [ADDR_W-1:0]       w_addr_arr  [NUM_CLIENTS];
  logic [LINE_W-1:0]       w_wdata_arr [NUM_CLIENTS];

  // Split the flattened client buses into per-client views
  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = c_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = c_wdata[gi*LINE_W +: LINE_W];
  end

  // A client being acknowledged this cycle still shows its old request level;
  // hide it so only a request raised after c_ready is treated as new.
  assign w_req_mask = c_req & ~r_c_ready;

  rr_pick #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (w_req_mask),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  // Next-state and next-output decode for the transaction/flush sequencer
  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_grant_nxt      = r_grant;
    w_flush_pend_nxt = r_flush_pend | sys_flush_req;
    w_arb_req_nxt    = 1'b0;
    w_arb_w_rb_nxt   = r_arb_w_rb;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_flush_req_nxt  = 1'b0;
    w_c_ready_nxt    = '0;
    w_c_rdata_nxt    = r_c_rdata;

    unique case (r_state)
      IDLE: begin
        // A flush arriving together with client requests takes priority
        if (r_flush_pend || sys_flush_req) begin
          w_flush_req_nxt = 1'b1;
          w_state_nxt     = FLUSH_ISSUE;
        end else if (w_pick_vld) begin
          w_grant_nxt    = w_pick_idx;
          w_arb_w_rb_nxt = c_w_rb[w_pick_idx];
          w_addr_nxt     = w_addr_arr[w_pick_idx];
          w_wdata_nxt    = w_wdata_arr[w_pick_idx];
          w_arb_req_nxt  = 1'b1;
          w_state_nxt    = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ready2arb) begin
          if (!r_arb_w_rb) begin
            w_c_rdata_nxt = rdata2arb;
          end
          w_c_ready_nxt[r_grant] = 1'b1;
          w_rr_ptr_nxt = (r_grant == IDX_W'(NUM_CLIENTS - 1)) ? '0 : r_grant + 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      FLUSH_ISSUE: begin
        w_state_nxt = FLUSH_START;
      end
      FLUSH_START: begin
        if (flush_ing) begin
          w_state_nxt = FLUSH_WAIT;
        end
      end
      FLUSH_WAIT: begin
        // Requests that arrived during the flush are covered by it
        if (!flush_ing) begin
          w_flush_pend_nxt = 1'b0;
          w_state_nxt      = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered-output update; reset drops any in-flight request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_flush_pend <= 1'b0;
      r_arb_req    <= 1'b0;
      r_arb_w_rb   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_flush_req  <= 1'b0;
      r_c_ready    <= '0;
      r_c_rdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_grant      <= w_grant_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_arb_req    <= w_arb_req_nxt;
      r_arb_w_rb   <= w_arb_w_rb_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_flush_req  <= w_flush_req_nxt;
      r_c_ready    <= w_c_ready_nxt;
      r_c_rdata    <= w_c_rdata_nxt;
    end
  end

  assign arb_req     = r_arb_req;
  assign arb_w_rb    = r_arb_w_rb;
  assign addr_in     = r_addr;
  assign wdata2cache = r_wdata;
  assign flush_req   = r_flush_req;
  assign c_ready     = r_c_ready;
  assign c_rdata     = r_c_rdata;
  assign flush_busy  = r_flush_pend;

endmodule : l2_arbiter
`default_nettype wire
